// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared definitions for the immediate-extension stage.
//   - SEL_* : extension format codes carried alongside each instruction
//   - OP_*  : opcodes (instr[15:11]) that select a non-NONE format
//   - imm_hdr_t : width-independent part of a FIFO entry {instr, sel};
//     the top level appends the DATA_W-wide immediate to form the entry.
package imm_ext_pkg;

  localparam logic [2:0] SEL_ZE5  = 3'b000;
  localparam logic [2:0] SEL_ZE8  = 3'b001;
  localparam logic [2:0] SEL_SE5  = 3'b010;
  localparam logic [2:0] SEL_SE8  = 3'b100;
  localparam logic [2:0] SEL_SE11 = 3'b110;
  localparam logic [2:0] SEL_NONE = 3'b111;

  // ZE5
  localparam logic [4:0] OP_01010 = 5'b01010;
  localparam logic [4:0] OP_01011 = 5'b01011;
  localparam logic [4:0] OP_10100 = 5'b10100;
  localparam logic [4:0] OP_10101 = 5'b10101;
  localparam logic [4:0] OP_10110 = 5'b10110;
  localparam logic [4:0] OP_10111 = 5'b10111;
  // ZE8
  localparam logic [4:0] OP_10010 = 5'b10010;
  // SE5
  localparam logic [4:0] OP_01000 = 5'b01000;
  localparam logic [4:0] OP_01001 = 5'b01001;
  localparam logic [4:0] OP_10000 = 5'b10000;
  localparam logic [4:0] OP_10001 = 5'b10001;
  localparam logic [4:0] OP_10011 = 5'b10011;
  // SE8
  localparam logic [4:0] OP_01100 = 5'b01100;
  localparam logic [4:0] OP_01101 = 5'b01101;
  localparam logic [4:0] OP_01110 = 5'b01110;
  localparam logic [4:0] OP_01111 = 5'b01111;
  localparam logic [4:0] OP_11000 = 5'b11000;
  localparam logic [4:0] OP_00101 = 5'b00101;
  localparam logic [4:0] OP_00111 = 5'b00111;
  // SE11
  localparam logic [4:0] OP_00100 = 5'b00100;
  localparam logic [4:0] OP_00110 = 5'b00110;

  typedef struct packed {
    logic [15:0] instr;
    logic [2:0]  sel;
  } imm_hdr_t;

endpackage

// File: rtl/imm_ext_dec.sv
// imm_ext_dec: combinational opcode decode and immediate extension.
//   instr_i [15:0]     instruction word (opcode in [15:11])
//   sel_o   [2:0]      extension format code (SEL_*)
//   imm_o   [DATA_W-1:0] extended immediate (0 for SEL_NONE)
module imm_ext_dec
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr_i,
  output logic [2:0]        sel_o,
  output logic [DATA_W-1:0] imm_o
);

  always_comb begin
    sel_o = SEL_NONE;
    case (instr_i[15:11])
      OP_01010, OP_01011, OP_10100,
      OP_10101, OP_10110, OP_10111:           sel_o = SEL_ZE5;
      OP_10010:                               sel_o = SEL_ZE8;
      OP_01000, OP_01001, OP_10000,
      OP_10001, OP_10011:                     sel_o = SEL_SE5;
      OP_01100, OP_01101, OP_01110, OP_01111,
      OP_11000, OP_00101, OP_00111:           sel_o = SEL_SE8;
      OP_00100, OP_00110:                     sel_o = SEL_SE11;
      default:                                sel_o = SEL_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (sel_o)
      SEL_ZE5:  imm_o = DATA_W'(instr_i[4:0]);
      SEL_ZE8:  imm_o = DATA_W'(instr_i[7:0]);
      SEL_SE5:  imm_o = {{(DATA_W-5){instr_i[4]}},   instr_i[4:0]};
      SEL_SE8:  imm_o = {{(DATA_W-8){instr_i[7]}},   instr_i[7:0]};
      SEL_SE11: imm_o = {{(DATA_W-11){instr_i[10]}}, instr_i[10:0]};
      default:  imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: decodes/extends the immediate of each incoming
// instruction and buffers {instr, sel, imm} in a DEPTH-entry FIFO.
//   clk, rst_n              clock / async active-low reset
//   flush                   drop all buffered entries (and this cycle's input)
//   in_valid/in_ready/in_instr      upstream handshake
//   out_valid/out_ready             downstream handshake
//   out_instr/out_sel/out_imm       head entry fields
//   perf_accept/perf_stall  saturating counters, built only when
//                           IMM_EXT_PERF_EN is defined (else tied to 0)
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [2:0]        out_sel,
  output logic [DATA_W-1:0] out_imm,
  output logic [CNT_W-1:0]  perf_accept,
  output logic [CNT_W-1:0]  perf_stall
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    imm_hdr_t          hdr;
    logic [DATA_W-1:0] imm;
  } entry_t;

  logic [2:0]        dec_sel;
  logic [DATA_W-1:0] dec_imm;

  imm_ext_dec #(.DATA_W(DATA_W)) u_dec (
    .instr_i (in_instr),
    .sel_o   (dec_sel),
    .imm_o   (dec_imm)
  );

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  // Ready depends only on stored count, so no out_ready -> in_ready path.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // DEPTH is a power of 2, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{hdr: '{instr: in_instr, sel: dec_sel}, imm: dec_imm};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Head entry drives the outputs directly; contents are don't-care when empty.
  assign out_instr = mem_q[rd_ptr_q].hdr.instr;
  assign out_sel   = mem_q[rd_ptr_q].hdr.sel;
  assign out_imm   = mem_q[rd_ptr_q].imm;

`ifdef IMM_EXT_PERF_EN
  logic [CNT_W-1:0] acc_q, stall_q;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (push && (acc_q != '1))                     acc_q   <= acc_q + CNT_W'(1);
      if (in_valid && !in_ready && (stall_q != '1))  stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign perf_accept = acc_q;
  assign perf_stall  = stall_q;
`else
  assign perf_accept = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed bench for imm_ext_stage (DATA_W=16 and 32).
// Perf-counter expectations follow IMM_EXT_PERF_EN (0 when undefined).
module tb_imm_ext_stage;

`ifdef IMM_EXT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic        in_ready, out_valid;
  logic [15:0] out_instr;
  logic [2:0]  out_sel;
  logic [15:0] out_imm;
  logic [15:0] perf_accept, perf_stall;

  logic        w_in_ready, w_out_valid;
  logic [15:0] w_out_instr;
  logic [2:0]  w_out_sel;
  logic [31:0] w_out_imm;
  logic [15:0] w_perf_accept, w_perf_stall;

  imm_ext_stage #(.DATA_W(16), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_sel(out_sel), .out_imm(out_imm),
    .perf_accept(perf_accept), .perf_stall(perf_stall)
  );

  imm_ext_stage #(.DATA_W(32), .DEPTH(2), .CNT_W(16)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_sel(w_out_sel), .out_imm(w_out_imm),
    .perf_accept(w_perf_accept), .perf_stall(w_perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-written format code per opcode 0..31.
  logic [2:0] exp_sel [32] = '{
    3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd4, 3'd6, 3'd4,   // 00000..00111
    3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4,   // 01000..01111
    3'd2, 3'd2, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0,   // 10000..10111
    3'd4, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7    // 11000..11111
  };

  int          acc_exp;
  logic [15:0] stall_base;
  logic [15:0] exp_imm;
  logic [15:0] a_i, b_i, c_i;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    acc_exp = 0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_sel",   64'(out_sel),   64'd0);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_perf_acc",  64'(perf_accept), 64'd0);
    chk("rst_perf_stall",64'(perf_stall),  64'd0);
    #10 rst_n = 1'b1;
    step();

    // Opcode sweep with instr[10:0] = 7FF.
    for (int op = 0; op < 32; op++) begin
      in_instr = {5'(op), 11'h7FF};
      in_valid = 1'b1;
      step();
      acc_exp++;
      in_valid = 1'b0;
      case (exp_sel[op])
        3'd0:    exp_imm = 16'h001F;
        3'd1:    exp_imm = 16'h00FF;
        3'd7:    exp_imm = 16'h0000;
        default: exp_imm = 16'hFFFF;
      endcase
      chk($sformatf("sweep_valid_op%0d", op), 64'(out_valid), 64'd1);
      chk($sformatf("sweep_instr_op%0d", op), 64'(out_instr), 64'({5'(op), 11'h7FF}));
      chk($sformatf("sweep_sel_op%0d", op),   64'(out_sel),   64'(exp_sel[op]));
      chk($sformatf("sweep_imm_op%0d", op),   64'(out_imm),   64'(exp_imm));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("sweep_drain_op%0d", op), 64'(out_valid), 64'd0);
    end

    // Width / sign boundaries, checked on both instances.
    in_instr = {5'b00100, 11'h400}; in_valid = 1'b1;
    step(); acc_exp++; in_valid = 1'b0;
    chk("se11_neg_w32", 64'(w_out_imm), 64'hFFFF_FC00);
    chk("se11_neg_w16", 64'(out_imm),   64'hFC00);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_instr = {5'b10010, 3'b000, 8'h80}; in_valid = 1'b1;
    step(); acc_exp++; in_valid = 1'b0;
    chk("ze8_w32", 64'(w_out_imm), 64'h0000_0080);
    chk("ze8_sel", 64'(w_out_sel), 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_instr = {5'b01000, 11'h00F}; in_valid = 1'b1;
    step(); acc_exp++; in_valid = 1'b0;
    chk("se5_pos_w32", 64'(w_out_imm), 64'h0000_000F);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Back-pressure: DEPTH=2, third instruction waits upstream.
    a_i = 16'h5001; b_i = 16'h6802; c_i = 16'h9003;
    stall_base = perf_stall;
    in_valid = 1'b1; in_instr = a_i;
    step(); acc_exp++;
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    in_instr = b_i;
    step(); acc_exp++;
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    in_instr = c_i;
    step();
    chk("bp_hold_instr1", 64'(out_instr), 64'(a_i));
    chk("bp_stall1", 64'(perf_stall), PERF ? 64'(stall_base + 16'd1) : 64'd0);
    step();
    chk("bp_hold_instr2", 64'(out_instr), 64'(a_i));
    chk("bp_ready_held", 64'(in_ready), 64'd0);
    chk("bp_stall2", 64'(perf_stall), PERF ? 64'(stall_base + 16'd2) : 64'd0);
    out_ready = 1'b1;
    step();   // pops A; C still stalled this edge
    chk("bp_head_b", 64'(out_instr), 64'(b_i));
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_stall3", 64'(perf_stall), PERF ? 64'(stall_base + 16'd3) : 64'd0);
    step();   // push C, pop B
    acc_exp++;
    in_valid = 1'b0;
    chk("bp_head_c", 64'(out_instr), 64'(c_i));
    chk("bp_valid_c", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("perf_accept", 64'(perf_accept), PERF ? 64'(acc_exp) : 64'd0);

    // Throughput: one per cycle, order preserved.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_instr = {5'b10010, 3'b000, 8'(8'h10 + k)};
      in_valid = 1'b1;
      step(); acc_exp++;
      chk($sformatf("tp_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("tp_instr%0d", k), 64'(out_instr), 64'({5'b10010, 3'b000, 8'(8'h10 + k)}));
      chk($sformatf("tp_imm%0d", k),   64'(out_imm),   64'(8'h10 + k));
      chk($sformatf("tp_ready%0d", k), 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("tp_drain", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush on a full FIFO with a simultaneous input.
    in_valid = 1'b1; in_instr = 16'h5111; step(); acc_exp++;
    in_instr = 16'h5222; step(); acc_exp++;
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_instr = 16'h5333;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b1; in_instr = 16'h5444;
    step(); acc_exp++; in_valid = 1'b0;
    chk("fl_next_instr", 64'(out_instr), 64'h5444);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("fl_only_one", 64'(out_valid), 64'd0);
    chk("fl_perf_keep", 64'(perf_accept), PERF ? 64'(acc_exp) : 64'd0);

    // Async reset between clock edges.
    in_valid = 1'b1; in_instr = 16'h5555;
    step(); in_valid = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready",  64'(in_ready),  64'd1);
    chk("ar_perf_acc",  64'(perf_accept), 64'd0);
    chk("ar_perf_stall",64'(perf_stall),  64'd0);
    chk("ar_w32_valid", 64'(w_out_valid), 64'd0);
    #3 rst_n = 1'b1;
    step();
    chk("ar_post_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
